// File: rtl/gray_pkg.sv
// Shared types and defaults for the serial Gray-to-binary decoder.
package gray_pkg;

    localparam int unsigned GRAY_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } gray_state_e;

endpackage

// File: rtl/gray_decoder_serial_if.sv
// Handshake bundle between a Gray source, the serial decoder and a binary consumer.
interface gray_decoder_serial_if
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             step_err;
    logic             busy;

    modport master (
        output in_valid,
        output gray_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  step_err,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  gray_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output step_err,
        output busy
    );

endinterface

// File: rtl/gray_step_checker.sv
// Flags a Gray word whose Hamming distance to the previous word is not exactly one.
module gray_step_checker #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] prev,
    input  logic             prev_valid,
    output logic             err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] w_diff;
    logic [CntW-1:0]  w_ones;

    assign w_diff = cur ^ prev;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + CntW'(w_diff[i]);
        end
    end

    // A repeated word (distance 0) counts as a violation too.
    assign err = prev_valid && (w_ones != CntW'(1));

endmodule

// File: rtl/gray_decoder_serial.sv
// Bit-serial Gray-to-binary decoder, MSB first, one bit per clock, valid/ready on both sides.
// Optional step check (Hamming distance to previous word) enabled by GRAY_STEP_CHECK_EN.
module gray_decoder_serial
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    gray_decoder_serial_if.slave bus
);

    localparam int unsigned     IdxW   = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);

    gray_state_e      r_state;
    gray_state_e      w_state_next;
    logic [WIDTH-1:0] r_g_reg;
    logic [WIDTH-1:0] r_acc;
    logic [IdxW-1:0]  r_idx;
    logic             r_carry;
    logic             w_accept;
    logic             w_bit;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_bit    = r_carry ^ r_g_reg[r_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (r_idx == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g_reg <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_g_reg <= bus.gray_in;
            r_acc   <= '0;
            r_idx   <= IdxTop;
            r_carry <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_acc[r_idx] <= w_bit;
            r_carry      <= w_bit;
            // Index parks at zero; the DONE transition takes over there.
            if (r_idx != '0) begin
                r_idx <= r_idx - IdxW'(1);
            end
        end
    end

    assign bus.bin_out = r_acc;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] r_prev_gray;
    logic             r_prev_valid;
    logic             r_step_err;
    logic             w_step_err;

    gray_step_checker #(
        .WIDTH(WIDTH)
    ) u_step_checker (
        .cur       (bus.gray_in),
        .prev      (r_prev_gray),
        .prev_valid(r_prev_valid),
        .err       (w_step_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_gray  <= '0;
            r_prev_valid <= 1'b0;
            r_step_err   <= 1'b0;
        end else if (w_accept) begin
            r_prev_gray  <= bus.gray_in;
            r_prev_valid <= 1'b1;
            r_step_err   <= w_step_err;
        end
    end

    assign bus.step_err = r_step_err;
`else
    assign bus.step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_decoder_serial.sv
// Directed, scoreboard-checked bench for gray_decoder_serial at WIDTH=4.
module tb_gray_decoder_serial;

    localparam int unsigned W = 4;
`ifdef GRAY_STEP_CHECK_EN
    localparam bit StepEn = 1'b1;
`else
    localparam bit StepEn = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] bin;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [W-1:0] m_prev = '0;
    logic         m_prev_v = 1'b0;

    gray_decoder_serial_if #(.WIDTH(W)) bus ();

    gray_decoder_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic model_err(input logic [W-1:0] g);
        return StepEn && m_prev_v && ($countones(g ^ m_prev) != 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    task automatic send(input logic [W-1:0] g, input logic [W-1:0] exp_bin,
                        input logic exp_err, input bit push);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.gray_in  = g;
        @(posedge clk);
        if (push) sb.push_back('{bin: exp_bin, err: exp_err});
        m_prev   = g;
        m_prev_v = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check(tag, bus.out_valid, 1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed output 0x%0h, expected no output", tag, bus.bin_out);
        end else begin
            e = sb.pop_front();
            check({tag, "_bin"}, bus.bin_out, e.bin);
            check({tag, "_err"}, bus.step_err, e.err);
        end
    endtask

    task automatic receive(input string tag);
        wait_out({tag, "_valid"});
        pop_check(tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_prev_v = 1'b0;
    endtask

    initial begin
        logic [W-1:0] gw;
        logic [W-1:0] seq [5];
        logic [4:0]   seq_err;
        exp_t         held;
        int           nacc;
        int           nrx;
        int           cyc;
        int           last_acc;

        bus.in_valid  = 1'b0;
        bus.gray_in   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_bin_out", bus.bin_out, 0);
        check("rst_step_err", bus.step_err, 0);

        // Latency: accepted at E0, out_valid seen at E0+W+1.
        send(4'b0110, 4'b0100, 1'b0, 1'b1);
        for (int k = 1; k <= W; k++) begin
            check($sformatf("lat_pre_E%0d_valid", k), bus.out_valid, 0);
            check($sformatf("lat_pre_E%0d_busy", k), bus.busy, 1);
            @(negedge clk);
        end
        check("lat_E5_valid", bus.out_valid, 1);
        receive("lat");

        send(4'b1000, 4'b1111, model_err(4'b1000), 1'b1);
        receive("dir_1000");
        send(4'b0000, 4'b0000, model_err(4'b0000), 1'b1);
        receive("dir_0000");

        for (int g = 0; g < 16; g++) begin
            gw = W'(g);
            send(gw, gray2bin(gw), model_err(gw), 1'b1);
            receive($sformatf("sweep_%0d", g));
        end

        // Backpressure: DONE holds, in_valid pulse ignored.
        send(4'b1010, gray2bin(4'b1010), model_err(4'b1010), 1'b1);
        wait_out("stall_valid");
        held = sb[0];
        for (int c = 0; c < 6; c++) begin
            check($sformatf("stall_valid_%0d", c), bus.out_valid, 1);
            check($sformatf("stall_bin_%0d", c), bus.bin_out, held.bin);
            check($sformatf("stall_in_ready_%0d", c), bus.in_ready, 0);
            if (c == 2) begin
                bus.in_valid = 1'b1;
                bus.gray_in  = 4'b0101;
            end
            if (c == 3) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        pop_check("stall");
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("stall_release_in_ready", bus.in_ready, 1);
        check("stall_release_valid", bus.out_valid, 0);
        repeat (8) @(negedge clk);
        check("stall_no_ghost", bus.out_valid, 0);

        // Reset during the 2nd SHIFT cycle discards the word.
        send(4'b0111, 4'b0101, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        m_prev_v = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        send(4'b0101, 4'b0110, 1'b0, 1'b1);
        receive("post_rst");

        do_reset();
        seq[0]  = 4'b0001;
        seq[1]  = 4'b0011;
        seq[2]  = 4'b0000;
        seq[3]  = 4'b0000;
        seq[4]  = 4'b0001;
        seq_err = StepEn ? 5'b01100 : 5'b00000;
        for (int i = 0; i < 5; i++) begin
            send(seq[i], gray2bin(seq[i]), seq_err[i], 1'b1);
            receive($sformatf("step_%0d", i));
        end

        // Back-to-back Gray-ordered stream.
        do_reset();
        nacc     = 0;
        nrx      = 0;
        cyc      = 0;
        last_acc = -1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.gray_in   = bin2gray(W'(0));
        while (nrx < 16 && cyc < 400) begin
            if (bus.in_valid && bus.in_ready) begin
                if (last_acc >= 0) check($sformatf("b2b_ii_%0d", nacc), cyc - last_acc, W + 2);
                last_acc = cyc;
                sb.push_back('{bin: W'(nacc), err: 1'b0});
                nacc++;
            end
            if (bus.out_valid) begin
                pop_check($sformatf("b2b_%0d", nrx));
                nrx++;
            end
            @(posedge clk);
            #1;
            if (nacc == 16) bus.in_valid = 1'b0;
            else bus.gray_in = bin2gray(W'(nacc));
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("b2b_count", nrx, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
